// File: rtl/mac_tx_crc_seq.sv
// Ethernet MAC transmit sequencer: frames the upstream byte stream onto GMII
// (preamble, SFD, payload, optional pad, FCS, inter-frame gap) and owns all
// control of the external crc32_gen block.
// Build option: define MAC_TX_PAD_EN to zero-pad short frames to MIN_PAYLOAD.
module mac_tx_crc_seq #(
    parameter int PREAMBLE_LEN = 7,
`ifdef MAC_TX_PAD_EN
    parameter int MIN_PAYLOAD  = 60,
`endif
    parameter int IFG_LEN      = 12
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tx_start,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_last,
    output logic       o_tx_ready,
    output logic       o_tx_busy,
    output logic       o_err_underrun,
    output logic       o_crc_init,
    output logic       o_crc_en,
    output logic       o_crc_read,
    output logic [7:0] o_crc_data,
    input  logic [7:0] i_crc_byte,
    output logic [7:0] o_gmii_txd,
    output logic       o_gmii_tx_en,
    output logic       o_gmii_tx_er
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SFD  = 3'd2,
        ST_DATA = 3'd3,
`ifdef MAC_TX_PAD_EN
        ST_PAD  = 3'd4,
`endif
        ST_FCS  = 3'd5,
        ST_IFG  = 3'd6
    } txState_t;

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0] FCS_LAST = 8'd3;
    // The IDLE cycle in which the next tx_start is accepted is itself a quiet
    // wire cycle, so the IFG state is one shorter than the wire gap.
    // IFG_LEN must therefore be at least 2.
    localparam logic [7:0] IFG_LAST = 8'(IFG_LEN - 2);

    txState_t   r_state;
    txState_t   w_nextState;
    logic [7:0] r_phaseCnt;
    logic [7:0] r_txd;
    logic       r_txEn;
    logic       r_txEr;
    logic [7:0] w_txd;
    logic       w_txEn;
    logic       w_txEr;

`ifdef MAC_TX_PAD_EN
    localparam logic [10:0] PAD_LAST = 11'(MIN_PAYLOAD - 1);
    logic [10:0] r_byteCnt;
`endif

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Phase counter for preamble, FCS and IFG lengths; cleared on every state change.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_phaseCnt <= 8'd0;
        end else if (w_nextState != r_state) begin
            r_phaseCnt <= 8'd0;
        end else if (r_state == ST_PRE || r_state == ST_FCS || r_state == ST_IFG) begin
            r_phaseCnt <= r_phaseCnt + 8'd1;
        end
    end

`ifdef MAC_TX_PAD_EN
    // Saturating count of bytes fed to the CRC (payload plus pad) for the pad decision.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_byteCnt <= 11'd0;
        end else if (r_state == ST_IDLE) begin
            r_byteCnt <= 11'd0;
        end else if (((r_state == ST_DATA) && i_tx_valid) || (r_state == ST_PAD)) begin
            if (r_byteCnt != 11'h7FF) begin
                r_byteCnt <= r_byteCnt + 11'd1;
            end
        end
    end
`endif

    // Next-state logic, CRC control and the byte to be put on the wire next cycle.
    always_comb begin
        w_nextState    = r_state;
        o_tx_ready     = 1'b0;
        o_tx_busy      = (r_state != ST_IDLE);
        o_err_underrun = 1'b0;
        o_crc_init     = 1'b0;
        o_crc_en       = 1'b0;
        o_crc_read     = 1'b0;
        o_crc_data     = 8'h00;
        w_txd          = 8'h00;
        w_txEn         = 1'b0;
        w_txEr         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_tx_start) begin
                    o_crc_init  = 1'b1;
                    w_nextState = ST_PRE;
                end
            end
            ST_PRE: begin
                w_txd  = 8'h55;
                w_txEn = 1'b1;
                if (r_phaseCnt == PRE_LAST) begin
                    w_nextState = ST_SFD;
                end
            end
            ST_SFD: begin
                w_txd       = 8'hD5;
                w_txEn      = 1'b1;
                w_nextState = ST_DATA;
            end
            ST_DATA: begin
                o_tx_ready = 1'b1;
                w_txEn     = 1'b1;
                if (i_tx_valid) begin
                    o_crc_en   = 1'b1;
                    o_crc_data = i_tx_data;
                    w_txd      = i_tx_data;
                    if (i_tx_last) begin
`ifdef MAC_TX_PAD_EN
                        if (r_byteCnt < PAD_LAST) begin
                            w_nextState = ST_PAD;
                        end else begin
                            w_nextState = ST_FCS;
                        end
`else
                        w_nextState = ST_FCS;
`endif
                    end
                end else begin
                    w_txEr         = 1'b1;
                    o_err_underrun = 1'b1;
                    w_nextState    = ST_IFG;
                end
            end
`ifdef MAC_TX_PAD_EN
            ST_PAD: begin
                w_txEn   = 1'b1;
                o_crc_en = 1'b1;
                if (r_byteCnt >= PAD_LAST) begin
                    w_nextState = ST_FCS;
                end
            end
`endif
            ST_FCS: begin
                o_crc_read = 1'b1;
                w_txd      = i_crc_byte;
                w_txEn     = 1'b1;
                if (r_phaseCnt == FCS_LAST) begin
                    w_nextState = ST_IFG;
                end
            end
            ST_IFG: begin
                if (r_phaseCnt >= IFG_LAST) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // GMII output register; reset drops the wire immediately, mid-frame included.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_txd  <= 8'h00;
            r_txEn <= 1'b0;
            r_txEr <= 1'b0;
        end else begin
            r_txd  <= w_txd;
            r_txEn <= w_txEn;
            r_txEr <= w_txEr;
        end
    end

    assign o_gmii_txd   = r_txd;
    assign o_gmii_tx_en = r_txEn;
    assign o_gmii_tx_er = r_txEr;

endmodule
